// File: rtl/psram_ui_pkg.sv
// -----------------------------------------------------------------------------
// psram_ui_pkg
// Shared widths and the controller state encoding for the PSRAM user-interface
// responder. One 128-bit beat carries four 32-bit DQ words and has one mask
// bit per byte.
// -----------------------------------------------------------------------------
package psram_ui_pkg;

   localparam int ADDR_WIDTH = 21;
   localparam int DQ_WIDTH   = 32;
   localparam int BEAT_WIDTH = 4 * DQ_WIDTH;
   localparam int MASK_WIDTH = BEAT_WIDTH / 8;

   typedef enum logic [2:0] {
      INIT      = 3'd0,
      IDLE      = 3'd1,
      WRITE     = 3'd2,
      READ_WAIT = 3'd3,
      READ      = 3'd4,
      RECOVER   = 3'd5
   } state_t;

endpackage : psram_ui_pkg

// File: rtl/psram_ui_responder_if.sv
// -----------------------------------------------------------------------------
// psram_ui_responder_if
// Command/data bus between a host (master) and the PSRAM responder (slave).
//   cmd, cmd_en, addr      : command, strobe and burst start address
//   wr_data, data_mask     : write beat and per-byte mask (1 = byte not written)
//   rd_data, rd_data_valid : read beat and its qualifier
//   init_done, cmd_err     : ready indication and sticky protocol-error flag
// -----------------------------------------------------------------------------
interface psram_ui_responder_if;
   import psram_ui_pkg::*;

   logic                  cmd;
   logic                  cmd_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [BEAT_WIDTH-1:0] wr_data;
   logic [MASK_WIDTH-1:0] data_mask;
   logic [BEAT_WIDTH-1:0] rd_data;
   logic                  rd_data_valid;
   logic                  init_done;
   logic                  cmd_err;

   modport master (
      output cmd, cmd_en, addr, wr_data, data_mask,
      input  rd_data, rd_data_valid, init_done, cmd_err
   );

   modport slave (
      input  cmd, cmd_en, addr, wr_data, data_mask,
      output rd_data, rd_data_valid, init_done, cmd_err
   );

endinterface : psram_ui_responder_if

// File: rtl/psram_ui_mem.sv
// -----------------------------------------------------------------------------
// psram_ui_mem
// Simple dual-port backing store: one byte-enabled write port, one read port
// with a single cycle of registered read latency.
//   clk   : clock
//   we    : write enable
//   be    : per-byte write enables (1 = write this byte)
//   waddr : write word index
//   wdata : write word
//   raddr : read word index, rdata valid on the following cycle
//   rdata : registered read word
// -----------------------------------------------------------------------------
module psram_ui_mem
   import psram_ui_pkg::*;
#(
   parameter int AW = 11
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [MASK_WIDTH-1:0] be,
   input  logic [AW-1:0]         waddr,
   input  logic [BEAT_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [BEAT_WIDTH-1:0] rdata
);

   logic [BEAT_WIDTH-1:0] mem [0:(1 << AW) - 1];

   // NOTE: the array and its read register carry no reset so the store maps
   // onto block RAM; contents after reset are simply whatever was there.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < MASK_WIDTH; b++) begin
            if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      rdata <= mem[raddr];
   end

endmodule : psram_ui_mem

// File: rtl/psram_ui_responder.sv
// -----------------------------------------------------------------------------
// psram_ui_responder
// Behavioural PSRAM responder behind a burst command interface. After an
// initialisation delay it accepts one command per T_CMD cycles: a write takes
// BURST_BEATS consecutive beats starting in the cmd_en cycle, a read returns
// BURST_BEATS beats starting RD_LAT cycles after cmd_en. Word index is
// addr[20:1] + beat, wrapping modulo the store depth.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, aborts any burst
//   bus   : slave side of psram_ui_responder_if
// -----------------------------------------------------------------------------
module psram_ui_responder
   import psram_ui_pkg::*;
#(
   parameter int BURST_BEATS = 32,
   parameter int T_CMD       = 42,
   parameter int RD_LAT      = 8,
   parameter int INIT_CYCLES = 100,
   parameter int MEM_AW      = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   psram_ui_responder_if.slave  bus
);

   localparam int CW = $clog2(T_CMD + 1);
   localparam int IW = $clog2(INIT_CYCLES + 1);
   localparam int BW = $clog2(BURST_BEATS + 1);

   localparam logic [BW-1:0] LAST_BEAT    = BW'(BURST_BEATS - 1);
   localparam logic [CW-1:0] LAST_SPACING = CW'(T_CMD - 1);
   localparam logic [CW-1:0] LAST_WAIT    = CW'(RD_LAT - 1);
   localparam logic [IW-1:0] LAST_INIT    = IW'(INIT_CYCLES - 1);

   // The RAM read register takes one of the RD_LAT cycles, so RD_LAT >= 2;
   // the whole read burst must fit inside the command spacing window.
   generate
      if ((RD_LAT + BURST_BEATS > T_CMD) || (RD_LAT < 2) || (MEM_AW > 20)) begin : g_bad_params
         $error("psram_ui_responder: illegal RD_LAT/BURST_BEATS/T_CMD/MEM_AW combination");
      end
   endgenerate

   state_t                state;
   state_t                state_nxt;
   logic [CW-1:0]         spacing_cnt;   // cycles since the accepted cmd_en cycle
   logic [IW-1:0]         init_cnt;
   logic [BW-1:0]         beat;
   logic [MEM_AW-1:0]     base;
   logic                  cmd_err_q;
   logic                  accept;
   logic                  spacing_done;
   logic                  mem_we;
   logic [MEM_AW-1:0]     mem_waddr;
   logic [MEM_AW-1:0]     mem_raddr;
   logic [BEAT_WIDTH-1:0] mem_q;
   logic                  unused_addr;

   assign accept       = (state == IDLE) && bus.cmd_en;
   assign spacing_done = (spacing_cnt >= LAST_SPACING);

   // NOTE: state_nxt gets its default before the case so every path assigns
   // it and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         INIT:      if (init_cnt == LAST_INIT) state_nxt = IDLE;
         IDLE: begin
            if (bus.cmd_en) begin
               if (!bus.cmd)              state_nxt = READ_WAIT;
               else if (BURST_BEATS > 1)  state_nxt = WRITE;
               else                       state_nxt = RECOVER;
            end
         end
         WRITE:     if (beat == LAST_BEAT) state_nxt = spacing_done ? IDLE : RECOVER;
         READ_WAIT: if (spacing_cnt == LAST_WAIT) state_nxt = READ;
         READ:      if (beat == LAST_BEAT) state_nxt = spacing_done ? IDLE : RECOVER;
         RECOVER:   if (spacing_done) state_nxt = IDLE;
         default:   state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= INIT;
         spacing_cnt <= '0;
         init_cnt    <= '0;
         beat        <= '0;
         base        <= '0;
         cmd_err_q   <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state == INIT) init_cnt <= init_cnt + 1'b1;

         if (accept) begin
            spacing_cnt <= CW'(1);
            base        <= bus.addr[MEM_AW:1];
            // Beat 0 of a write goes straight to the RAM in the cmd_en cycle.
            beat        <= bus.cmd ? BW'(1) : '0;
         end else if (state != IDLE && state != INIT) begin
            spacing_cnt <= spacing_cnt + 1'b1;
         end

         if (state == WRITE || state == READ) beat <= beat + 1'b1;

         if (bus.cmd_en && state != IDLE) cmd_err_q <= 1'b1;
      end
   end

   assign mem_we    = (accept && bus.cmd) || (state == WRITE);
   assign mem_waddr = (state == WRITE) ? base + MEM_AW'(beat) : bus.addr[MEM_AW:1];
   // The read address runs one beat ahead of rd_data to cover the RAM register;
   // the last READ_WAIT cycle presents beat 0.
   assign mem_raddr = (state == READ) ? base + MEM_AW'(beat + 1'b1) : base;

   psram_ui_mem #(
      .AW (MEM_AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .be    (~bus.data_mask),
      .waddr (mem_waddr),
      .wdata (bus.wr_data),
      .raddr (mem_raddr),
      .rdata (mem_q)
   );

   // Outputs decode straight from reset-cleared state so an assertion of rst_n
   // drops them in the same cycle.
   assign bus.init_done     = (state != INIT);
   assign bus.rd_data_valid = (state == READ);
   assign bus.rd_data       = (state == READ) ? mem_q : '0;
   assign bus.cmd_err       = cmd_err_q;

   assign unused_addr = ^bus.addr;

endmodule : psram_ui_responder
